// File: rtl/sync_filter.sv
// sync_filter: multi-channel input synchroniser with optional debounce and edge pulses.
// Define SYNC_DEBOUNCE_EN to build the per-channel debounce counters.
module sync_filter #(
  parameter int WIDTH           = 4,
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);
  if (STAGES < 2 || DEBOUNCE_CYCLES < 1 || WIDTH < 1) begin : g_bad_params
    $error("sync_filter: invalid parameters");
  end
  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  assign sync_out   = sync_q[STAGES-1];
  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`ifdef SYNC_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_out[i] == level_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = sync_out[i];
        cnt_d[i]   = '0;
      end else cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign level_d = sync_out;
`endif
  assign rise_d = level_d & ~level_q;
  assign fall_d = ~level_d & level_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_in};
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed checks of sync_filter timing, filtering, pulses and reset.
module tb_sync_filter;
  localparam int W = 4;
`ifdef SYNC_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  logic clk = 0, rst = 0;
  logic [W-1:0] async_in = '0;
  logic [W-1:0] sync_out, level_out, rise_pulse, fall_pulse;
  logic [4*W-1:0] obs, exp_v;
  int tests = 0, fails = 0;

  sync_filter #(.WIDTH(W), .STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(sync_out),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;
  assign obs = {sync_out, level_out, rise_pulse, fall_pulse};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    async_in = 4'hF;
    #2 rst = 1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      tests++;
      if (obs !== '0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d got %h want %h", k, obs, 16'h0);
      end
    end
    rst = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      exp_v = {(k >= 2 ? 4'hF : 4'h0), (k >= LAT ? 4'hF : 4'h0), (k == LAT ? 4'hF : 4'h0), 4'h0};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL reset_release k%0d got %h want %h", k, obs, exp_v);
      end
    end
    async_in = 0;
    tick(12);
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL settle_low got %h want %h", obs, 16'h0);
    end
  endtask

  task automatic test_glitch;
    logic [W-1:0] s, l, r, f;
    async_in = 4'h1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 3) async_in = 0;
      s = (k >= 2 && k <= 4) ? 4'h1 : 4'h0;
`ifdef SYNC_DEBOUNCE_EN
      l = 0; r = 0; f = 0;
`else
      l = (k >= 3 && k <= 5) ? 4'h1 : 4'h0;
      r = (k == 3) ? 4'h1 : 4'h0;
      f = (k == 6) ? 4'h1 : 4'h0;
`endif
      exp_v = {s, l, r, f};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL glitch k%0d got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_accept_release;
    async_in = 4'h2;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 10) async_in = 0;
      exp_v = {((k >= 2 && k <= 11) ? 4'h2 : 4'h0), ((k >= LAT && k < 10 + LAT) ? 4'h2 : 4'h0),
               (k == LAT ? 4'h2 : 4'h0), (k == 10 + LAT ? 4'h2 : 4'h0)};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL accept_release k%0d got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_independent;
    async_in = 4'h4;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 1) async_in = 4'hC;
      exp_v = {((k >= 2 ? 4'h4 : 4'h0) | (k >= 3 ? 4'h8 : 4'h0)),
               ((k >= LAT ? 4'h4 : 4'h0) | (k >= LAT + 1 ? 4'h8 : 4'h0)),
               ((k == LAT ? 4'h4 : 4'h0) | (k == LAT + 1 ? 4'h8 : 4'h0)), 4'h0};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL independent k%0d got %h want %h", k, obs, exp_v);
      end
    end
    async_in = 0;
    tick(12);
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL independent_settle got %h want %h", obs, 16'h0);
    end
  endtask

  task automatic test_midcount_reset;
    async_in = 4'h1;
    tick(2);
    tests++;
    if (sync_out !== 4'h1) begin
      fails++;
      $display("FAIL midreset_pre sync got %h want %h", sync_out, 4'h1);
    end
    rst = 1;
    #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL midreset_async got %h want %h", obs, 16'h0);
    end
    tick(1);
    rst = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      exp_v = {(k >= 2 ? 4'h1 : 4'h0), (k >= LAT ? 4'h1 : 4'h0), (k == LAT ? 4'h1 : 4'h0), 4'h0};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL midreset_restart k%0d got %h want %h", k, obs, exp_v);
      end
    end
    async_in = 0;
    tick(12);
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_accept_release;
    test_independent;
    test_midcount_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
